button_cond: RTL and testbench



---
 rtl/button_cond.sv | 103 ++++++++++
 tb/tb_button_cond.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/button_cond.sv
// Synchronizes, debounces and conditions a raw pad button; optional `BUTTON_COND_TOGGLE_EN turns button_inp into a press toggle.
// Latency DEBOUNCE_CYCLES+2 clocks from btn_raw to button_inp/btn_press; no backpressure, outputs are plain flop pulses/levels.
module button_cond #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic button_inp,
  output logic btn_press,
  output logic btn_release,
  output logic step_tick
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [DW-1:0] r_db_cnt;
  logic          r_press;
  logic          r_release;
  logic          r_inp;
  logic [TW-1:0] r_tick_cnt;
  logic          r_tick;

  logic w_flip;
  logic w_stable_nxt;
  logic w_rise;
  logic w_fall;
  logic w_inp_nxt;
  logic w_wrap;

  // Pulses and the level are computed from next-state so they land in the same cycle as the flip.
  assign w_flip       = (r_sync2 != r_stable) && (r_db_cnt == DB_LAST);
  assign w_stable_nxt = w_flip ? r_sync2 : r_stable;
  assign w_rise       = w_flip & r_sync2;
  assign w_fall       = w_flip & ~r_sync2;
  assign w_wrap       = (r_tick_cnt == TICK_LAST);

`ifdef BUTTON_COND_TOGGLE_EN
  assign w_inp_nxt = r_inp ^ w_rise;
`else
  assign w_inp_nxt = w_stable_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable  <= 1'b0;
      r_db_cnt  <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_inp     <= 1'b0;
    end else begin
      r_stable  <= w_stable_nxt;
      r_press   <= w_rise;
      r_release <= w_fall;
      r_inp     <= w_inp_nxt;
      if (r_sync2 == r_stable || w_flip) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // Tick is suppressed in the cycle the level drops, so a partial period never leaks a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      if (!r_inp) begin
        r_tick_cnt <= '0;
      end else if (w_wrap) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      r_tick <= r_inp & w_inp_nxt & w_wrap;
    end
  end

  assign button_inp  = r_inp;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign step_tick   = r_tick;

endmodule

// File: tb/tb_button_cond.sv
// Scoreboard bench for button_cond: expected output events are queued with their cycle and matched by a monitor.
module tb_button_cond;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_PRESS = 2;
  localparam int K_REL = 3;
  localparam int K_TICK = 4;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic button_inp, btn_press, btn_release, step_tick;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];

  button_cond #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8)) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .button_inp(button_inp),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int k);
    exp_q.push_back(ev_t'{c, k});
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every observed output event must match the head of the expectation queue.
  initial begin : monitor
    logic prev_inp;
    logic [4:0] seen;
    ev_t e;
    prev_inp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        seen = '0;
        seen[K_RISE]  = (button_inp === 1'b1) && !prev_inp;
        seen[K_FALL]  = (button_inp === 1'b0) && prev_inp;
        seen[K_PRESS] = (btn_press === 1'b1);
        seen[K_REL]   = (btn_release === 1'b1);
        seen[K_TICK]  = (step_tick === 1'b1);
        for (int k = 0; k < 5; k++) begin
          if (seen[k]) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL event: got kind %0d at cycle %0d, expected no event", k, cyc);
            end else begin
              e = exp_q.pop_front();
              if (e.cyc != cyc || e.kind != k) begin
                errors++;
                $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         k, cyc, e.kind, e.cyc);
              end
            end
          end
        end
      end
      prev_inp = (button_inp === 1'b1);
    end
  end

  initial begin : watchdog
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin : stim
    int c;
    int d;
    int r;
    rst = 1'b1;
    btn_raw = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_inp", button_inp, 1'b0);
    check("rst_press", btn_press, 1'b0);
    check("rst_release", btn_release, 1'b0);
    check("rst_tick", step_tick, 1'b0);

`ifdef BUTTON_COND_TOGGLE_EN
    rst = 1'b0;
    @(negedge clk);
    c = cyc;
    btn_raw = 1'b1;
    push(c + 6, K_RISE);  push(c + 6, K_PRESS);
    push(c + 14, K_TICK); push(c + 16, K_REL);
    push(c + 22, K_TICK);
    push(c + 26, K_FALL); push(c + 26, K_PRESS);
    push(c + 36, K_REL);
    wait_to(c + 10); btn_raw = 1'b0;
    wait_to(c + 18); check("toggle_held", button_inp, 1'b1);
    wait_to(c + 20); btn_raw = 1'b1;
    wait_to(c + 30); btn_raw = 1'b0;
    wait_to(c + 50); check("toggle_off", button_inp, 1'b0);
`else
    // Reset held with the button pressed, then a fresh debounce.
    btn_raw = 1'b1;
    c = cyc;
    wait_to(c + 2);
    rst = 1'b0;
    check("rsthold_inp", button_inp, 1'b0);
    check("rsthold_press", btn_press, 1'b0);
    check("rsthold_release", btn_release, 1'b0);
    check("rsthold_tick", step_tick, 1'b0);
    c = cyc;
    push(c + 6, K_RISE);  push(c + 6, K_PRESS);
    push(c + 12, K_FALL); push(c + 12, K_REL);
    wait_to(c + 5); check("rsthold_early", button_inp, 1'b0);
    wait_to(c + 6); btn_raw = 1'b0;
    wait_to(c + 20);

    // Clean press.
    c = cyc;
    btn_raw = 1'b1;
    push(c + 6, K_RISE);  push(c + 6, K_PRESS);
    push(c + 13, K_FALL); push(c + 13, K_REL);
    wait_to(c + 6); check("press_hi", btn_press, 1'b1);
    wait_to(c + 7); check("press_lo", btn_press, 1'b0);
    btn_raw = 1'b0;
    wait_to(c + 25);

    // Glitch of 3 clocks.
    c = cyc;
    btn_raw = 1'b1;
    wait_to(c + 3); btn_raw = 1'b0;
    wait_to(c + 15); check("glitch_inp", button_inp, 1'b0);

    // Hold and tick.
    c = cyc;
    r = c + 6;
    btn_raw = 1'b1;
    push(r, K_RISE);      push(r, K_PRESS);
    push(r + 8, K_TICK);  push(r + 16, K_TICK); push(r + 24, K_TICK);
    push(r + 30, K_FALL); push(r + 30, K_REL);
    wait_to(r + 24); btn_raw = 1'b0;
    wait_to(r + 50); check("hold_inp_low", button_inp, 1'b0);

    // Reset in the middle of a debounce.
    c = cyc;
    btn_raw = 1'b1;
    wait_to(c + 2); rst = 1'b1;
    wait_to(c + 3); rst = 1'b0;
    d = cyc;
    push(d + 6, K_RISE); push(d + 6, K_PRESS);
    wait_to(d + 5); check("midrst_early", button_inp, 1'b0);
    wait_to(d + 6); btn_raw = 1'b0;
    push(d + 12, K_FALL); push(d + 12, K_REL);
    wait_to(d + 25);
`endif

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL event: got nothing, expected kind %0d at cycle %0d", e.kind, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
